// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux_arb round-robin arbiter and select controller.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StExpire
    } arb_state_t;

    // Select value driven while no grant has ever been issued since reset.
    localparam int unsigned ARB_IDX_RESET = 0;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin pick: first asserted request searching last+1, last+2, ... mod N.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);

    // Walk from the farthest candidate to the nearest so the nearest match is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                winner = IW'((int'(last) + k) % N);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// Round-robin arbiter driving the select of a shared N:1 data mux.
// Optional grant timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DW       = 1,
    parameter int unsigned MAX_HOLD = 8,
    localparam int unsigned IW      = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] data,
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_valid,
    output logic [DW-1:0]   y,
    output logic            expired
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("mux_arb: N must be in 2..16");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("mux_arb: MAX_HOLD must be at least 2");
    end

    arb_state_t     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  last_q, last_d;
    logic [IW-1:0]  pick_idx;
    logic           pick_valid;
    logic           take;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0]  hold_q, hold_d;
`endif

    // In GRANT, last_q equals the holder, so one picker serves both IDLE and re-arbitration.
    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        take    = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            StGrant: begin
                if (req[idx_q]) begin
`ifdef MUX_ARB_TIMEOUT_EN
                    if (hold_q >= CW'(MAX_HOLD)) begin
                        state_d = StExpire;
                        gnt_d   = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
`endif
                end else if (pick_valid) begin
                    take = 1'b1;
                end else begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end
            end
            // IDLE, and the cycle after an expiry, arbitrate from scratch.
            default: begin
                state_d = StIdle;
                if (pick_valid) begin
                    take = 1'b1;
                end
            end
        endcase

        if (take) begin
            state_d         = StGrant;
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            idx_d           = pick_idx;
            last_d          = pick_idx;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_d          = CW'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= IW'(ARB_IDX_RESET);
            last_q  <= IW'(N - 1);
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;
    // Gate the mux output so a stale select never leaks data.
    assign y         = gnt_valid ? data[int'(idx_q) * DW +: DW] : '0;

`ifdef MUX_ARB_TIMEOUT_EN
    assign expired = (state_q == StExpire);
`else
    assign expired = 1'b0;
`endif

endmodule

// File: doc/mux_arb.md
# mux_arb

Round-robin arbiter and select controller that shares one N:1 data mux among N requesters. Each requester raises a request, the block grants exactly one at a time and drives the mux select from the registered grant. The selected requester's data appears on the shared output. It sits directly upstream of the gate-level mux datapath and is the only block allowed to drive its select.

## Interface
- N, 4, number of requesters (2..16)
- DW, 1, data width per requester
- MAX_HOLD, 8, maximum consecutive grant cycles when the timeout feature is compiled in (≥2)
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- req  input  N  per-requester request, level-sensitive
- data  input  N*DW  requester data, requester i at bits [i*DW +: DW]
- gnt  output  N  one-hot grant, registered
- gnt_idx  output  $clog2(N)  index of the granted requester, registered; mux select
- gnt_valid  output  1  high when any grant is held
- y  output  DW  data[gnt_idx] when gnt_valid, else 0 (combinational from registered select)
- expired  output  1  one-cycle pulse on forced revoke; tied 0 when the timeout feature is compiled out

## Operation
- States: IDLE, GRANT, EXPIRE (EXPIRE exists only with the timeout feature).
- Priority pointer `last` holds the most recent grantee. Search order is last+1, last+2, … mod N. The first asserted req wins.
- IDLE: if any req is high, go to GRANT. Set gnt to the winner, gnt_idx to its index, last to the winner.
- GRANT, holder's req still high: keep the grant unchanged. A higher-priority request does not preempt.
- GRANT, holder's req low:
  - If another req is high, re-arbitrate at the same edge (zero bubble). The search starts after the releasing holder.
  - Otherwise go to IDLE with gnt = 0.
- A holder that drops and re-raises req in consecutive cycles loses priority to other pending requesters.
- gnt is always one-hot or zero. gnt_valid = |gnt.
- y = 0 whenever gnt_valid is 0. This keeps the mux output from being driven by stale data.
- Reset (asynchronous, at any time, including mid-grant):
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, expired = 0.
  - last = N-1, so requester 0 has top priority after reset.
  - State = IDLE, hold counter = 0.
  - The first rising clk edge with rst_n high performs a normal IDLE arbitration.

## Timing
- Grant latency: req is sampled at edge k. gnt is high after edge k, i.e. one cycle from request to grant.
- Release latency: holder drops req before edge k. At edge k, gnt either clears or moves to the next requester.
- y follows gnt_idx combinationally. Valid data is seen in the same cycle gnt is seen.
- Single requester held continuously keeps the grant indefinitely when the timeout feature is compiled out.
- Simultaneous events are resolved at one edge as follows:
  - Holder release plus new requests: re-arbitrate.
  - Release plus reset: reset wins.
  - Expiry plus release: treat as a release; no expired pulse.

## Configuration
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter counts cycles in GRANT.
  - At the edge ending the MAX_HOLD-th consecutive grant cycle with the holder's req still high, revoke the grant and enter EXPIRE for one cycle.
  - In EXPIRE, gnt = 0 and expired = 1.
  - Next edge behaves as IDLE, with last still pointing at the revoked requester, so it has lowest priority.
  - The counter resets on every new grant.
- Undefined: no counter, no EXPIRE state, expired tied 0, grants unbounded.

## Structure
- Package mux_arb_pkg contains:
  - State enum `arb_state_t` (IDLE, GRANT, EXPIRE).
  - Localparam helper for the index width.
  - Constant `ARB_IDX_RESET`.
- Sub-module rr_pick: purely combinational round-robin pick.
  - Inputs: req[N], last.
  - Outputs: winner index and any-valid flag.
  - The top-level uses it for both the IDLE grant and the zero-bubble re-arbitration.

## Test plan
- Reset then req=4'b0110 → after one edge gnt=4'b0010, gnt_idx=1, y=data[1]. Hold req[1] 5 cycles → grant unchanged.
- Holder 1 drops req with req[2],req[3] high → next edge gnt=4'b0100, no idle cycle. Then drop req[2] → gnt=4'b1000.
- All four req held, each holder drops after 1 cycle → grant order 0,1,2,3,0. gnt stays one-hot every cycle.
- rst_n low asynchronously mid-grant (between edges) → gnt, gnt_valid, y go 0 immediately. After release, req=4'b1000 → gnt=4'b1000.
- No requests → gnt=0, gnt_valid=0, y=0 with data all ones.
- MUX_ARB_TIMEOUT_EN, MAX_HOLD=8:
  - req[0] held, req[2] high → gnt[0] for 8 cycles, then expired=1 with gnt=0 for one cycle, then gnt=4'b0100.
  - With only req[0] held → regranted to 0 after the EXPIRE cycle.
